// File: rtl/dsm_decimator.sv
// Second-order CIC (sinc^2) decimator: turns a unipolar 1-bit delta-sigma stream
// into RES-bit unsigned samples, one pulsed sample per 2^DEC_LOG2 accepted bits.
module dsm_decimator #(
  parameter int RES      = 8,
  parameter int DEC_LOG2 = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bit_in,
  input  logic           in_en,
  output logic [RES-1:0] dout,
  output logic           dout_valid
);

  localparam int W  = 2 * DEC_LOG2 + 1;
  localparam int SH = 2 * DEC_LOG2 - RES;

  // A full-scale period (every bit set) produces exactly R^2, the only value with the top bit set.
  localparam logic [W-1:0] FULL_SCALE = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]        r_i1;
  logic [W-1:0]        r_i2;
  logic [W-1:0]        r_i2_d;
  logic [W-1:0]        r_c1_d;
  logic [W-1:0]        r_c2;
  logic [DEC_LOG2-1:0] r_dcnt;
  logic                r_tick;
  logic [1:0]          r_warm;
  logic                r_stage_vld;
  logic [RES-1:0]      r_dout;
  logic                r_dout_valid;

  logic [W-1:0]        w_c1;
  logic [W-1:0]        w_c2;
  logic [RES-1:0]      w_sample;

  assign w_c1     = r_i2 - r_i2_d;
  assign w_c2     = w_c1 - r_c1_d;
  assign w_sample = (r_c2 == FULL_SCALE) ? {RES{1'b1}} : r_c2[SH +: RES];

  // Integrators and decimation counter advance only on accepted bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1   <= '0;
      r_i2   <= '0;
      r_dcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make i2 accumulate the pre-update i1,
      // which is exactly the one-edge skew the second integrator needs.
      if (in_en) begin
        r_i1   <= r_i1 + {{(W-1){1'b0}}, bit_in};
        r_i2   <= r_i2 + r_i1;
        r_dcnt <= r_dcnt + DEC_LOG2'(1);
      end
      r_tick <= in_en && (&r_dcnt);
    end
  end

  // Comb stage runs on the tick regardless of in_en; the first two results
  // only prime the delay registers and are withheld from the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i2_d      <= '0;
      r_c1_d      <= '0;
      r_c2        <= '0;
      r_warm      <= '0;
      r_stage_vld <= 1'b0;
    end else begin
      r_stage_vld <= 1'b0;
      if (r_tick) begin
        r_i2_d <= r_i2;
        r_c1_d <= w_c1;
        r_c2   <= w_c2;
        if (r_warm == 2'd2) begin
          r_stage_vld <= 1'b1;
        end else begin
          r_warm <= r_warm + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= r_stage_vld;
      if (r_stage_vld) begin
        r_dout <= w_sample;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed bench for dsm_decimator: constant, alternating and modulator-loopback
// streams, gated acceptance, and mid-period reset.
module tb_dsm_decimator;

  localparam int RES      = 8;
  localparam int DEC_LOG2 = 8;
  localparam int R        = 256;
  localparam int FIRST    = 3 * R + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       in_en;
  logic [7:0] dout;
  logic       dout_valid;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mod_acc;

  always #5 clk = ~clk;

  dsm_decimator #(.RES(RES), .DEC_LOG2(DEC_LOG2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .in_en      (in_en),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic cyc(input logic b, input logic en);
    bit_in = b;
    in_en  = en;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // First-order delta-sigma modulator: carry-out of an 8-bit phase accumulator.
  task automatic mod_bit(input logic [7:0] din, output logic b);
    logic [8:0] s;
    s       = {1'b0, mod_acc} + {1'b0, din};
    mod_acc = s[7:0];
    b       = s[8];
  endtask

  // Continuous in_en=1 stream; mode 0 zeros, 1 ones, 2 alt starting 1, 3 alt starting 0, 4 modulator.
  task automatic run_continuous(input string name, input int mode, input logic [7:0] din,
                                input logic [7:0] exp);
    int   pulses;
    logic prev;
    logic b;
    pulses  = 0;
    prev    = 1'b0;
    do_reset();
    mod_acc = 8'h00;
    for (int k = 1; k <= 5 * R + 2; k++) begin
      case (mode)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = (k % 2) == 1;
        3:       b = (k % 2) == 0;
        default: mod_bit(din, b);
      endcase
      cyc(b, 1'b1);
      if (dout_valid) begin
        n_checks++;
        if (k !== FIRST + pulses * R) begin
          n_errors++;
          $display("FAIL %s pulse_edge: got edge %0d, expected %0d", name, k, FIRST + pulses * R);
        end
        n_checks++;
        if (dout !== exp) begin
          n_errors++;
          $display("FAIL %s dout: got 0x%02h, expected 0x%02h (edge %0d)", name, dout, exp, k);
        end
        n_checks++;
        if (prev !== 1'b0) begin
          n_errors++;
          $display("FAIL %s back_to_back: valid high in consecutive cycles at edge %0d", name, k);
        end
        pulses++;
      end
      prev = dout_valid;
    end
    n_checks++;
    if (pulses !== 3) begin
      n_errors++;
      $display("FAIL %s pulse_count: got %0d, expected 3", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bit_in = 1'b0;
    in_en  = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (dout !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_dout: got 0x%02h, expected 0x00", dout);
    end
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid: got %0b, expected 0", dout_valid);
    end
  endtask

  task automatic test_all_zero();
    run_continuous("all_zero", 0, 8'h00, 8'h00);
  endtask

  task automatic test_all_ones();
    run_continuous("all_ones", 1, 8'h00, 8'hFF);
  endtask

  task automatic test_alternating();
    run_continuous("alt_phase1", 2, 8'h00, 8'h80);
    run_continuous("alt_phase0", 3, 8'h00, 8'h80);
  endtask

  task automatic test_loopback_40();
    run_continuous("loop_40", 4, 8'h40, 8'h40);
  endtask

  task automatic test_loopback_c0_gated();
    int   accepted;
    int   cycles;
    int   pulses;
    int   h1;
    int   h2;
    logic b;
    logic en;
    accepted = 0;
    cycles   = 0;
    pulses   = 0;
    h1       = 0;
    h2       = 0;
    do_reset();
    mod_acc = 8'h00;
    while ((accepted < 5 * R || cycles < 4 + accepted * 0 + cycles - cycles + 0) && cycles < 20000) begin
      if (accepted < 5 * R) begin
        en = 1'($urandom_range(0, 1));
        b  = 1'b0;
        if (en) mod_bit(8'hC0, b);
      end else begin
        en = 1'b0;
        b  = 1'b0;
      end
      cyc(b, en);
      if (en) accepted++;
      cycles++;
      if (dout_valid) begin
        n_checks++;
        if (dout !== 8'hC0) begin
          n_errors++;
          $display("FAIL gated dout: got 0x%02h, expected 0xC0", dout);
        end
        n_checks++;
        if ((h2 % R) !== 0) begin
          n_errors++;
          $display("FAIL gated pulse_alignment: accepted bits at tick %0d, expected multiple of %0d", h2, R);
        end
        pulses++;
      end
      h2 = h1;
      h1 = accepted;
      if (accepted >= 5 * R) break;
    end
    n_checks++;
    if (accepted !== 5 * R) begin
      n_errors++;
      $display("FAIL gated timeout: accepted %0d bits, expected %0d", accepted, 5 * R);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0);
      if (dout_valid) begin
        n_checks++;
        if (dout !== 8'hC0) begin
          n_errors++;
          $display("FAIL gated tail_dout: got 0x%02h, expected 0xC0", dout);
        end
        pulses++;
      end
    end
    n_checks++;
    if (pulses !== 5 - 2) begin
      n_errors++;
      $display("FAIL gated pulse_count: got %0d, expected %0d", pulses, 5 - 2);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    do_reset();
    for (int k = 1; k <= 3 * R + 100; k++) cyc(1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (dout !== 8'h00) begin
      n_errors++;
      $display("FAIL midreset_dout: got 0x%02h, expected 0x00", dout);
    end
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_valid: got %0b, expected 0", dout_valid);
    end
    for (int k = 1; k <= 4 * R + 2; k++) begin
      cyc(1'b1, 1'b1);
      if (dout_valid) begin
        n_checks++;
        if (k !== FIRST + pulses * R) begin
          n_errors++;
          $display("FAIL midreset pulse_edge: got edge %0d, expected %0d", k, FIRST + pulses * R);
        end
        n_checks++;
        if (dout !== 8'hFF) begin
          n_errors++;
          $display("FAIL midreset dout: got 0x%02h, expected 0xFF", dout);
        end
        pulses++;
      end
    end
    n_checks++;
    if (pulses !== 2) begin
      n_errors++;
      $display("FAIL midreset pulse_count: got %0d, expected 2", pulses);
    end
  endtask

  initial begin
    rst    = 1'b1;
    bit_in = 1'b0;
    in_en  = 1'b0;
    test_reset();
    test_all_zero();
    test_all_ones();
    test_alternating();
    test_loopback_40();
    test_loopback_c0_gated();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
